// File: rtl/snitch_icache_refill_writer_if.sv
// Refill writer bus bundle: miss request, memory request/response and
// lookup-stage write port of the instruction cache refill writer.
// The "master" modport is the refill writer's view, "slave" is the
// surrounding cache/memory view.
interface snitch_icache_refill_writer_if #(
   parameter int unsigned FETCH_AW   = 32,
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned BEAT_WIDTH = 32,
   parameter int unsigned SET_COUNT  = 2,
   parameter int unsigned LINE_COUNT = 64,
   parameter int unsigned TAG_WIDTH  = FETCH_AW - $clog2(LINE_WIDTH/8) - $clog2(LINE_COUNT),
   parameter int unsigned ID_WIDTH   = 4
) ();

   localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT);
   localparam int unsigned SET_ALIGN   = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1;

   // Miss request from the lookup stage
   logic [FETCH_AW-1:0]    miss_addr_i;
   logic [ID_WIDTH-1:0]    miss_id_i;
   logic                   miss_valid_i;
   logic                   miss_ready_o;

   // Line fetch request towards memory
   logic [FETCH_AW-1:0]    mem_req_addr_o;
   logic                   mem_req_valid_o;
   logic                   mem_req_ready_i;

   // Beat response from memory
   logic [BEAT_WIDTH-1:0]  mem_rsp_data_i;
   logic                   mem_rsp_error_i;
   logic                   mem_rsp_last_i;
   logic                   mem_rsp_valid_i;
   logic                   mem_rsp_ready_o;

   // Line write into the cache arrays
   logic [COUNT_ALIGN-1:0] write_addr_o;
   logic [SET_ALIGN-1:0]   write_set_o;
   logic [LINE_WIDTH-1:0]  write_data_o;
   logic [TAG_WIDTH-1:0]   write_tag_o;
   logic                   write_error_o;
   logic                   write_valid_o;
   logic                   write_ready_i;

   // Completion and status
   logic [ID_WIDTH-1:0]    done_id_o;
   logic                   done_valid_o;
   logic                   busy_o;

   modport master (
      input  miss_addr_i, miss_id_i, miss_valid_i,
      output miss_ready_o,
      output mem_req_addr_o, mem_req_valid_o,
      input  mem_req_ready_i,
      input  mem_rsp_data_i, mem_rsp_error_i, mem_rsp_last_i, mem_rsp_valid_i,
      output mem_rsp_ready_o,
      output write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o, write_valid_o,
      input  write_ready_i,
      output done_id_o, done_valid_o, busy_o
   );

   modport slave (
      output miss_addr_i, miss_id_i, miss_valid_i,
      input  miss_ready_o,
      input  mem_req_addr_o, mem_req_valid_o,
      output mem_req_ready_i,
      output mem_rsp_data_i, mem_rsp_error_i, mem_rsp_last_i, mem_rsp_valid_i,
      input  mem_rsp_ready_o,
      input  write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o, write_valid_o,
      output write_ready_i,
      input  done_id_o, done_valid_o, busy_o
   );

endinterface

// File: rtl/snitch_icache_refill_writer.sv
// Instruction cache refill writer: accepts one miss at a time, fetches the
// line from memory beat by beat, assembles it and writes it into the cache
// way chosen by a round-robin victim counter.
// Optional feature: define SNITCH_ICACHE_REFILL_PERF_EN to add refill and
// error performance counters (perf_refills_o, perf_errors_o).
module snitch_icache_refill_writer #(
   parameter int unsigned FETCH_AW   = 32,
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned BEAT_WIDTH = 32,
   parameter int unsigned SET_COUNT  = 2,
   parameter int unsigned LINE_COUNT = 64,
   parameter int unsigned TAG_WIDTH  = FETCH_AW - $clog2(LINE_WIDTH/8) - $clog2(LINE_COUNT),
   parameter int unsigned ID_WIDTH   = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   snitch_icache_refill_writer_if.master bus
`ifdef SNITCH_ICACHE_REFILL_PERF_EN
   ,
   output logic [31:0] perf_refills_o,
   output logic [31:0] perf_errors_o
`endif
);

   localparam int unsigned BEATS       = LINE_WIDTH / BEAT_WIDTH;
   localparam int unsigned CNT_W       = $clog2(BEATS) + 1;
   localparam int unsigned SET_ALIGN   = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1;
   localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT);
   localparam int unsigned LINE_ALIGN  = $clog2(LINE_WIDTH / 8);
   localparam logic [FETCH_AW-1:0] LINE_MASK =
      ~((FETCH_AW'(1) << LINE_ALIGN) - FETCH_AW'(1));

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      RECV  = 2'd2,
      WRITE = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [FETCH_AW-1:0]   addr_q, addr_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [LINE_WIDTH-1:0] line_q, line_d;
   logic                  err_q, err_d;
   logic [SET_ALIGN-1:0]  victim_q, victim_d;

   // Handshake outputs are registered copies of the next-state decode
   logic miss_ready_q, mem_req_valid_q, mem_rsp_ready_q, write_valid_q, busy_q;

   logic             beat_accept;
   logic             write_done;
   logic [BEATS-1:0] beat_hit;

   assign beat_accept = mem_rsp_ready_q & bus.mem_rsp_valid_i;
   assign write_done  = write_valid_q & bus.write_ready_i;

   // One-hot select of the line buffer slot addressed by the beat counter;
   // a saturated counter selects nothing, so surplus beats are dropped.
   for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat_hit
      assign beat_hit[gi] = (cnt_q == CNT_W'(gi));
   end

   // Next-state and datapath update for the refill sequence
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      id_d     = id_q;
      cnt_d    = cnt_q;
      line_d   = line_q;
      err_d    = err_q;
      victim_d = victim_q;
      unique case (state_q)
         IDLE: begin
            if (bus.miss_valid_i) begin
               addr_d  = bus.miss_addr_i;
               id_d    = bus.miss_id_i;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.mem_req_ready_i) begin
               cnt_d   = '0;
               line_d  = '0;
               err_d   = 1'b0;
               state_d = RECV;
            end
         end
         RECV: begin
            if (beat_accept) begin
               for (int k = 0; k < BEATS; k++) begin
                  if (beat_hit[k]) line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = bus.mem_rsp_data_i;
               end
               if (cnt_q != CNT_W'(BEATS)) cnt_d = cnt_q + 1'b1;
               err_d = err_q | bus.mem_rsp_error_i;
               if (bus.mem_rsp_last_i) begin
                  // A burst ending before the line is full leaves holes
                  if (cnt_q < CNT_W'(BEATS - 1)) err_d = 1'b1;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (bus.write_ready_i) begin
               victim_d = (victim_q == SET_ALIGN'(SET_COUNT - 1)) ? '0 : victim_q + 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         id_q            <= '0;
         cnt_q           <= '0;
         line_q          <= '0;
         err_q           <= 1'b0;
         victim_q        <= '0;
         miss_ready_q    <= 1'b1;
         mem_req_valid_q <= 1'b0;
         mem_rsp_ready_q <= 1'b0;
         write_valid_q   <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         id_q            <= id_d;
         cnt_q           <= cnt_d;
         line_q          <= line_d;
         err_q           <= err_d;
         victim_q        <= victim_d;
         miss_ready_q    <= (state_d == IDLE);
         mem_req_valid_q <= (state_d == REQ);
         mem_rsp_ready_q <= (state_d == RECV);
         write_valid_q   <= (state_d == WRITE);
         busy_q          <= (state_d != IDLE);
      end
   end

   assign bus.miss_ready_o    = miss_ready_q;
   assign bus.mem_req_addr_o  = addr_q & LINE_MASK;
   assign bus.mem_req_valid_o = mem_req_valid_q;
   assign bus.mem_rsp_ready_o = mem_rsp_ready_q;
   assign bus.write_addr_o    = addr_q[LINE_ALIGN +: COUNT_ALIGN];
   assign bus.write_set_o     = victim_q;
   assign bus.write_data_o    = line_q;
   assign bus.write_tag_o     = TAG_WIDTH'(addr_q >> (LINE_ALIGN + COUNT_ALIGN));
   assign bus.write_error_o   = err_q;
   assign bus.write_valid_o   = write_valid_q;
   assign bus.done_id_o       = id_q;
   assign bus.done_valid_o    = write_done;
   assign bus.busy_o          = busy_q;

`ifdef SNITCH_ICACHE_REFILL_PERF_EN
   logic [31:0] perf_refills_q, perf_refills_d;
   logic [31:0] perf_errors_q, perf_errors_d;

   // Count completed refills and those delivered with an error flag
   always_comb begin
      perf_refills_d = perf_refills_q;
      perf_errors_d  = perf_errors_q;
      if (write_done) begin
         perf_refills_d = perf_refills_q + 32'd1;
         if (err_q) perf_errors_d = perf_errors_q + 32'd1;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_refills_q <= '0;
         perf_errors_q  <= '0;
      end else begin
         perf_refills_q <= perf_refills_d;
         perf_errors_q  <= perf_errors_d;
      end
   end

   assign perf_refills_o = perf_refills_q;
   assign perf_errors_o  = perf_errors_q;
`endif

endmodule

// File: tb/tb_snitch_icache_refill_writer.sv
// Directed testbench for snitch_icache_refill_writer with default parameters.
// Inputs change just after the falling edge, outputs are checked on the
// falling edge (or 1 time unit after a same-cycle input change).
module tb_snitch_icache_refill_writer;

   logic clk;
   logic rst_n;
   int   checks;
   int   fails;

   snitch_icache_refill_writer_if bif ();

`ifdef SNITCH_ICACHE_REFILL_PERF_EN
   logic [31:0] perf_refills;
   logic [31:0] perf_errors;
`endif

   snitch_icache_refill_writer dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .bus            (bif)
`ifdef SNITCH_ICACHE_REFILL_PERF_EN
      ,
      .perf_refills_o (perf_refills),
      .perf_errors_o  (perf_errors)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts and reports on mismatch
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full refill: miss, line request, nb beats (last on the final one),
   // optional write stall with a competing miss held high, then the write.
   task automatic refill(input logic [31:0] addr, input logic [3:0] id, input int nb,
                         input logic [31:0] seed, input logic [7:0] err_mask,
                         input logic [31:0] exp_req, input logic [5:0] exp_waddr,
                         input logic [21:0] exp_tag, input logic [127:0] exp_data,
                         input logic exp_err, input logic exp_set, input int stall);
      bif.miss_valid_i = 1'b1;
      bif.miss_addr_i  = addr;
      bif.miss_id_i    = id;
      #1;
      chk("miss_ready_idle", bif.miss_ready_o, 1'b1);
      @(negedge clk);
      bif.miss_valid_i = 1'b0;
      chk("req_valid", bif.mem_req_valid_o, 1'b1);
      chk("req_addr", bif.mem_req_addr_o, exp_req);
      chk("busy_req", bif.busy_o, 1'b1);
      chk("miss_ready_req", bif.miss_ready_o, 1'b0);
      chk("rsp_ready_req", bif.mem_rsp_ready_o, 1'b0);
      bif.mem_req_ready_i = 1'b1;
      @(negedge clk);
      bif.mem_req_ready_i = 1'b0;
      chk("rsp_ready_recv", bif.mem_rsp_ready_o, 1'b1);
      chk("req_valid_recv", bif.mem_req_valid_o, 1'b0);
      for (int i = 0; i < nb; i++) begin
         bif.mem_rsp_valid_i = 1'b1;
         bif.mem_rsp_data_i  = seed * (i + 1);
         bif.mem_rsp_error_i = err_mask[i];
         bif.mem_rsp_last_i  = (i == nb - 1);
         @(negedge clk);
      end
      bif.mem_rsp_valid_i = 1'b0;
      bif.mem_rsp_error_i = 1'b0;
      bif.mem_rsp_last_i  = 1'b0;
      chk("write_valid", bif.write_valid_o, 1'b1);
      chk("write_addr", bif.write_addr_o, exp_waddr);
      chk("write_tag", bif.write_tag_o, exp_tag);
      chk("write_data", bif.write_data_o, exp_data);
      chk("write_error", bif.write_error_o, exp_err);
      chk("write_set", bif.write_set_o, exp_set);
      chk("rsp_ready_write", bif.mem_rsp_ready_o, 1'b0);
      chk("done_early", bif.done_valid_o, 1'b0);
      for (int s = 0; s < stall; s++) begin
         bif.miss_valid_i = 1'b1;
         bif.miss_addr_i  = 32'hDEAD_BEEF;
         @(negedge clk);
         chk("stall_write_valid", bif.write_valid_o, 1'b1);
         chk("stall_write_data", bif.write_data_o, exp_data);
         chk("stall_write_set", bif.write_set_o, exp_set);
         chk("stall_miss_ready", bif.miss_ready_o, 1'b0);
         chk("stall_done", bif.done_valid_o, 1'b0);
      end
      bif.miss_valid_i  = 1'b0;
      bif.write_ready_i = 1'b1;
      #1;
      chk("done_valid", bif.done_valid_o, 1'b1);
      chk("done_id", bif.done_id_o, id);
      @(negedge clk);
      bif.write_ready_i = 1'b0;
      chk("done_cleared", bif.done_valid_o, 1'b0);
      chk("write_valid_cleared", bif.write_valid_o, 1'b0);
      chk("miss_ready_back", bif.miss_ready_o, 1'b1);
      chk("busy_cleared", bif.busy_o, 1'b0);
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rst_n  = 1'b0;
      bif.miss_addr_i     = '0;
      bif.miss_id_i       = '0;
      bif.miss_valid_i    = 1'b0;
      bif.mem_req_ready_i = 1'b0;
      bif.mem_rsp_data_i  = '0;
      bif.mem_rsp_error_i = 1'b0;
      bif.mem_rsp_last_i  = 1'b0;
      bif.mem_rsp_valid_i = 1'b0;
      bif.write_ready_i   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_miss_ready", bif.miss_ready_o, 1'b1);
      chk("rst_req_valid", bif.mem_req_valid_o, 1'b0);
      chk("rst_rsp_ready", bif.mem_rsp_ready_o, 1'b0);
      chk("rst_write_valid", bif.write_valid_o, 1'b0);
      chk("rst_done", bif.done_valid_o, 1'b0);
      chk("rst_busy", bif.busy_o, 1'b0);
      chk("rst_write_data", bif.write_data_o, 128'h0);
      chk("rst_req_addr", bif.mem_req_addr_o, 32'h0);
      chk("rst_write_set", bif.write_set_o, 1'b0);
      chk("rst_write_error", bif.write_error_o, 1'b0);

      // Reference refill, set 0
      refill(32'h0000_1234, 4'd3, 4, 32'h11, 8'h00, 32'h0000_1230, 6'h23, 22'h4,
             128'h00000044_00000033_00000022_00000011, 1'b0, 1'b1 ^ 1'b1, 0);
      // Back-to-back, set 1
      refill(32'h0000_5678, 4'd5, 4, 32'h101, 8'h00, 32'h0000_5670, 6'h27, 22'h15,
             128'h00000404_00000303_00000202_00000101, 1'b0, 1'b1, 0);
      // Third wraps to set 0, error on beat 2 only
      refill(32'hABCD_EF00, 4'hA, 4, 32'h1000_0001, 8'h02, 32'hABCD_EF00, 6'h30, 22'h2AF37B,
             128'h40000004_30000003_20000002_10000001, 1'b1, 1'b0, 0);
      // Clean refill after the error, write stalled 10 cycles, set 1
      refill(32'h0000_0040, 4'd1, 4, 32'h5, 8'h00, 32'h0000_0040, 6'h04, 22'h0,
             128'h00000014_0000000F_0000000A_00000005, 1'b0, 1'b1, 10);
      // Short burst: last on beat 2, upper half zero, error, set 0
      refill(32'h0000_0080, 4'd2, 2, 32'h7, 8'h00, 32'h0000_0080, 6'h08, 22'h0,
             128'h00000000_00000000_0000000E_00000007, 1'b1, 1'b0, 0);
`ifdef SNITCH_ICACHE_REFILL_PERF_EN
      chk("perf_refills", perf_refills, 32'd5);
      chk("perf_errors", perf_errors, 32'd2);
`endif

      // Abort: reset during beat 2 of a refill while the victim points at set 1
      bif.miss_valid_i = 1'b1;
      bif.miss_addr_i  = 32'h0000_0100;
      bif.miss_id_i    = 4'd7;
      @(negedge clk);
      bif.miss_valid_i = 1'b0;
      chk("abort_req_valid", bif.mem_req_valid_o, 1'b1);
      bif.mem_req_ready_i = 1'b1;
      @(negedge clk);
      bif.mem_req_ready_i = 1'b0;
      chk("abort_rsp_ready", bif.mem_rsp_ready_o, 1'b1);
      bif.mem_rsp_valid_i = 1'b1;
      bif.mem_rsp_data_i  = 32'hAA;
      @(negedge clk);
      bif.mem_rsp_data_i  = 32'hBB;
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_write_valid", bif.write_valid_o, 1'b0);
      chk("abort_busy", bif.busy_o, 1'b0);
      chk("abort_miss_ready", bif.miss_ready_o, 1'b1);
      chk("abort_rsp_ready_rst", bif.mem_rsp_ready_o, 1'b0);
      chk("abort_req_valid_rst", bif.mem_req_valid_o, 1'b0);
      chk("abort_write_data", bif.write_data_o, 128'h0);
      chk("abort_write_set", bif.write_set_o, 1'b0);
      chk("abort_done", bif.done_valid_o, 1'b0);
      chk("abort_req_addr", bif.mem_req_addr_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bif.mem_rsp_last_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("inflight_rsp_ready", bif.mem_rsp_ready_o, 1'b0);
         chk("inflight_write_valid", bif.write_valid_o, 1'b0);
         chk("inflight_busy", bif.busy_o, 1'b0);
      end
      bif.mem_rsp_valid_i = 1'b0;
      bif.mem_rsp_last_i  = 1'b0;

      // Six beats with last on the sixth: beats 5-6 dropped, no error, set 0
      refill(32'h0000_00C0, 4'd6, 6, 32'h3, 8'h00, 32'h0000_00C0, 6'h0C, 22'h0,
             128'h0000000C_00000009_00000006_00000003, 1'b0, 1'b0, 0);
`ifdef SNITCH_ICACHE_REFILL_PERF_EN
      chk("perf_refills_after_rst", perf_refills, 32'd1);
      chk("perf_errors_after_rst", perf_errors, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/snitch_icache_refill_writer.md
SNITCH_ICACHE_REFILL_WRITER -- requirements
Module: snitch_icache_refill_writer

Interface
REQ-001: Parameter FETCH_AW, default 32, fetch/memory address width in bits.
REQ-002: Parameter LINE_WIDTH, default 128, cache line width in bits.
REQ-003: Parameter BEAT_WIDTH, default 32, memory response beat width; LINE_WIDTH SHALL be a multiple of it; BEATS = LINE_WIDTH/BEAT_WIDTH.
REQ-004: Parameter SET_COUNT, default 2, number of ways; SET_ALIGN = max(1, clog2(SET_COUNT)).
REQ-005: Parameter LINE_COUNT, default 64, lines per way; COUNT_ALIGN = clog2(LINE_COUNT); LINE_ALIGN = clog2(LINE_WIDTH/8).
REQ-006: Parameter TAG_WIDTH, default FETCH_AW-LINE_ALIGN-COUNT_ALIGN; parameter ID_WIDTH, default 4.
REQ-007: clk_i  in  1  clock; rst_ni  in  1  asynchronous, active-low reset.
REQ-008: miss_addr_i  in  FETCH_AW  missed fetch address; miss_id_i  in  ID_WIDTH  request id; miss_valid_i  in  1; miss_ready_o  out  1.
REQ-009: mem_req_addr_o  out  FETCH_AW  line-aligned fetch address; mem_req_valid_o  out  1; mem_req_ready_i  in  1.
REQ-010: mem_rsp_data_i  in  BEAT_WIDTH; mem_rsp_error_i  in  1; mem_rsp_last_i  in  1; mem_rsp_valid_i  in  1; mem_rsp_ready_o  out  1.
REQ-011: write_addr_o  out  COUNT_ALIGN; write_set_o  out  SET_ALIGN; write_data_o  out  LINE_WIDTH; write_tag_o  out  TAG_WIDTH; write_error_o  out  1; write_valid_o  out  1; write_ready_i  in  1 (lookup-stage write port).
REQ-012: done_id_o  out  ID_WIDTH; done_valid_o  out  1  one-cycle pulse on completed refill; busy_o  out  1  FSM not IDLE.

Function
REQ-013: FSM states IDLE, REQ, RECV, WRITE; IDLE->REQ on miss_valid_i&&miss_ready_o; REQ->RECV on mem_req_ready_i; RECV->WRITE on accepted beat with mem_rsp_last_i; WRITE->IDLE on write_ready_i.
REQ-014: miss_ready_o SHALL be 1 only in IDLE; accepted miss_addr_i/miss_id_i SHALL be registered.
REQ-015: mem_req_addr_o = registered address with low LINE_ALIGN bits zeroed; mem_req_valid_o high only in REQ and held until mem_req_ready_i.
REQ-016: mem_rsp_ready_o SHALL be 1 only in RECV; beat counter (clog2(BEATS)+1 bits) starts at 0 on entry to RECV.
REQ-017: Accepted beat k < BEATS SHALL be written to line buffer bits [k*BEAT_WIDTH +: BEAT_WIDTH]; beats with k >= BEATS SHALL be discarded, counter saturates.
REQ-018: Line buffer SHALL be cleared to 0 on entry to RECV; last arriving before BEATS beats leaves unfilled beats 0 and SHALL force write_error_o=1.
REQ-019: write_error_o = OR of mem_rsp_error_i over all accepted beats of the refill, plus REQ-018 short-burst condition.
REQ-020: write_addr_o = addr[LINE_ALIGN +: COUNT_ALIGN]; write_tag_o = addr >> (LINE_ALIGN+COUNT_ALIGN) truncated to TAG_WIDTH.
REQ-021: write_valid_o high only in WRITE, all write_* outputs stable until write_ready_i.
REQ-022: write_set_o = round-robin victim counter; counter increments on each completed write, wraps from SET_COUNT-1 to 0; constant 0 when SET_COUNT=1.
REQ-023: done_valid_o SHALL pulse for exactly the cycle write_valid_o&&write_ready_i, with done_id_o = registered id.
REQ-024: Latency: miss accepted cycle N, mem_req_valid_o at N+1; write_valid_o asserted cycle after last beat accepted.
REQ-025: Only one refill outstanding; new misses SHALL be back-pressured until IDLE.

Reset
REQ-026: On rst_ni low: FSM IDLE, victim counter 0, beat counter 0, line buffer 0, error flag 0, registered addr/id 0.
REQ-027: Reset outputs: miss_ready_o=1 after reset release; mem_req_valid_o, mem_rsp_ready_o, write_valid_o, done_valid_o, busy_o = 0; data outputs 0.
REQ-028: Reset asserted mid-refill SHALL abort it with no write issued; in-flight memory beats after release are ignored (mem_rsp_ready_o=0 in IDLE).

Configuration
REQ-029: Macro SNITCH_ICACHE_REFILL_PERF_EN: when defined, adds output perf_refills_o (32 bits, reset 0) incrementing on each done_valid_o, wrapping 0xFFFF_FFFF->0, and perf_errors_o (32 bits) incrementing on done with write_error_o=1.
REQ-030: Without SNITCH_ICACHE_REFILL_PERF_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification (defaults; FETCH_AW=32, LINE_WIDTH=128, BEAT_WIDTH=32, SET_COUNT=2, LINE_COUNT=64)
REQ-031: Miss 0x0000_1234 id 3, beats 0x11,0x22,0x33,0x44 (last on 4th) -> mem_req_addr_o=0x0000_1230, write_addr_o=0x23, write_tag_o=0x4, write_data_o=0x00000044_00000033_00000022_00000011, write_set_o=0, done_id_o=3.
REQ-032: Second refill back-to-back -> write_set_o=1; third -> write_set_o=0 (wrap).
REQ-033: Error on beat 2 only -> write_error_o=1, data still assembled; next clean refill -> write_error_o=0.
REQ-034: last on beat 2 of 4 -> upper 64 bits 0, write_error_o=1; 6 beats with last on 6th -> beats 5-6 dropped, write_error_o=0.
REQ-035: write_ready_i held low 10 cycles, miss_valid_i held high -> write_* stable, miss_ready_o=0 throughout, single done pulse.
REQ-036: rst_ni asserted during RECV beat 2 -> no write_valid_o, all outputs per REQ-027, next refill completes normally with write_set_o=0.
